sar_search: RTL and testbench

- Successive-approximation search engine. It is the initiator/consumer side of the magnitude comparator interface.
- It drives a probe value onto a comparator's b input. The comparator's a input carries an unknown value x.
- It consumes the eq/lt/gt responses and resolves x bit-by-bit, MSB first.
- Used for threshold discovery, ADC-style SAR loops and calibration sweeps.

---
 rtl/sar_search.sv | 173 +++++++++++++++++
 tb/tb_sar_search.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search.sv
// sar_search -- successive-approximation search engine.
//
// Drives a probe value onto a magnitude comparator's b input and resolves
// the unknown value x on the comparator's a input one bit at a time, MSB
// first. Each probe is acc | (1 << idx). A gt response keeps that bit, an lt
// response drops it, and an eq response ends the search early.
//
// Optional feature (macro SAR_TIMEOUT_EN): a watchdog aborts the search when
// cmp_valid stays low for TIMEOUT consecutive PROBE cycles. The search then
// ends with err=1 and result=acc, and done still pulses. When the macro is
// undefined, PROBE waits indefinitely and TIMEOUT is unused.
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-high reset
//   start        begin a search (sampled only in IDLE)
//   probe        value presented to comparator b (registered)
//   probe_valid  high exactly in PROBE: probe stable, response requested
//   cmp_valid    comparator response valid this cycle
//   cmp_eq/lt/gt comparator flags (x == / < / > probe)
//   busy         high while a search is in progress
//   done         one-cycle pulse when a search ends
//   result       resolved x, held until the next accepted start
//   err          last search aborted, held until the next accepted start
//   steps        probes consumed by the last search
//
// Handshake: a response is consumed on a rising edge where probe_valid and
// cmp_valid are both high. probe does not change while probe_valid is high
// and cmp_valid is low. cmp_valid outside PROBE is ignored.
module sar_search #(
  parameter int WIDTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [WIDTH-1:0]           probe,
  output logic                       probe_valid,
  input  logic                       cmp_valid,
  input  logic                       cmp_eq,
  input  logic                       cmp_lt,
  input  logic                       cmp_gt,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] steps
);

  localparam int SW = $clog2(WIDTH + 1);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;

  logic             one_hot;
  logic [IW-1:0]    idx_dn;
  logic [WIDTH-1:0] acc_upd;
  logic             finish;
  logic             timeout;

  // A response is legal only when exactly one of the three flags is set.
  always_comb begin
    one_hot = 1'b0;
    case ({cmp_eq, cmp_lt, cmp_gt})
      3'b100, 3'b010, 3'b001: one_hot = 1'b1;
      default:                one_hot = 1'b0;
    endcase
  end

  assign idx_dn  = idx - IW'(1);
  assign acc_upd = cmp_gt ? (acc | (WIDTH'(1) << idx)) : acc;

  // The search ends on an illegal response, an eq, or after the LSB decision.
  assign finish = cmp_valid && (!one_hot || cmp_eq || (idx == '0));

`ifdef SAR_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] wd;

  // Fires on the TIMEOUT-th consecutive PROBE cycle without a response.
  assign timeout = (state == S_PROBE) && !cmp_valid && (wd == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd <= '0;
    end else if (state != S_PROBE || cmp_valid) begin
      wd <= '0;
    end else if (!timeout) begin
      wd <= wd + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_PROBE;
      S_PROBE: if (finish || timeout) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign probe_valid = (state == S_PROBE);
  assign busy        = (state == S_PROBE);
  assign done        = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      idx    <= '0;
      probe  <= '0;
      result <= '0;
      err    <= 1'b0;
      steps  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            idx   <= IW'(WIDTH - 1);
            steps <= '0;
            err   <= 1'b0;
            probe <= WIDTH'(1) << (WIDTH - 1);
          end
        end
        S_PROBE: begin
          if (cmp_valid) begin
            steps <= steps + SW'(1);
            if (!one_hot) begin
              err    <= 1'b1;
              result <= acc;
            end else if (cmp_eq) begin
              result <= probe;
            end else begin
              acc <= acc_upd;
              if (idx == '0) begin
                result <= acc_upd;
              end else begin
                idx   <= idx_dn;
                probe <= acc_upd | (WIDTH'(1) << idx_dn);
              end
            end
          end else if (timeout) begin
            err    <= 1'b1;
            result <= acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_search.sv
module tb_sar_search;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] probe;
  logic         probe_valid;
  logic         cmp_valid;
  logic         cmp_eq;
  logic         cmp_lt;
  logic         cmp_gt;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         err;
  logic [3:0]   steps;

  // behavioural comparator with hidden x; inj forces an illegal lt+gt reply
  logic [W-1:0] x_hid = '0;
  logic         inj   = 1'b0;

  assign cmp_eq = inj ? 1'b0 : (x_hid == probe);
  assign cmp_lt = inj ? 1'b1 : (x_hid <  probe);
  assign cmp_gt = inj ? 1'b1 : (x_hid >  probe);

  int checks = 0;
  int errors = 0;

  sar_search #(.WIDTH(W), .TIMEOUT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .probe       (probe),
    .probe_valid (probe_valid),
    .cmp_valid   (cmp_valid),
    .cmp_eq      (cmp_eq),
    .cmp_lt      (cmp_lt),
    .cmp_gt      (cmp_gt),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .err         (err),
    .steps       (steps)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  typedef struct {
    logic [W-1:0] x;
    int           wait_n;     // low cmp_valid cycles before each reply
    int           inj_at;     // probe number that gets lt+gt (0 = never)
    bit           mid_start;  // pulse start while the search is running
    logic [W-1:0] exp_result;
    int           exp_steps;
    logic         exp_err;
    int           exp_cycles; // edges from start sampling to done visible
  } vec_t;

  vec_t vecs[7];

  // driver + probe-sequence model: expected probe = acc_m | (1 << idx_m)
  task automatic run_vec(input vec_t v, input int n);
    logic [W-1:0] acc_m;
    logic [W-1:0] exp_p;
    int           idx_m;
    int           nprobe;
    int           waitcnt;
    int           cyc;
    bit           seen_done;
    string        tag;
    tag       = $sformatf("v%0d", n);
    x_hid     = v.x;
    inj       = 1'b0;
    acc_m     = '0;
    idx_m     = W - 1;
    nprobe    = 0;
    waitcnt   = 0;
    seen_done = 0;
    @(negedge clk);
    start     = 1'b1;
    cmp_valid = 1'b0;
    @(posedge clk);
    cyc = 1;
    while (cyc < 200) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen_done = 1;
        break;
      end
      check({tag, "_probe_valid"}, probe_valid, 1);
      check({tag, "_busy"}, busy, 1);
      exp_p = acc_m | (W'(1) << idx_m);
      check({tag, "_probe"}, probe, exp_p);
      if (waitcnt < v.wait_n) begin
        cmp_valid = 1'b0;
        waitcnt++;
      end else begin
        cmp_valid = 1'b1;
        waitcnt   = 0;
        nprobe++;
        if (nprobe == v.inj_at) inj = 1'b1;
        if (!inj) begin
          if (v.x > exp_p) acc_m = exp_p;
          if (idx_m > 0) idx_m--;
        end
      end
      if (v.mid_start && nprobe == 2 && waitcnt == 1) start = 1'b1;
      @(posedge clk);
      cyc++;
    end
    cmp_valid = 1'b0;
    inj       = 1'b0;
    check({tag, "_done_seen"}, seen_done, 1);
    check({tag, "_cycles"}, cyc, v.exp_cycles);
    check({tag, "_result"}, result, v.exp_result);
    check({tag, "_steps"}, steps, v.exp_steps);
    check({tag, "_err"}, err, v.exp_err);
    check({tag, "_busy_at_done"}, busy, 0);
    check({tag, "_pv_at_done"}, probe_valid, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    @(negedge clk);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_result_held"}, result, v.exp_result);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_probe"}, probe, 0);
    check({tag, "_probe_valid"}, probe_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_steps"}, steps, 0);
  endtask

  initial begin
    int cyc;
    bit seen_done;

    vecs[0] = '{8'h80, 0, 0, 1'b0, 8'h80, 1, 1'b0, 2};
    vecs[1] = '{8'h05, 0, 0, 1'b0, 8'h05, 8, 1'b0, 9};
    vecs[2] = '{8'h00, 0, 0, 1'b0, 8'h00, 8, 1'b0, 9};
    vecs[3] = '{8'hFF, 0, 0, 1'b0, 8'hFF, 8, 1'b0, 9};
    vecs[4] = '{8'h37, 0, 0, 1'b0, 8'h37, 8, 1'b0, 9};
    vecs[5] = '{8'h5A, 3, 0, 1'b1, 8'h5A, 7, 1'b0, 29};
    vecs[6] = '{8'h05, 0, 3, 1'b0, 8'h00, 3, 1'b1, 4};

    rst       = 1'b1;
    start     = 1'b0;
    cmp_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset");

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // reset in the middle of a search: outputs clear, no done pulse
    x_hid = 8'h37;
    @(negedge clk);
    start     = 1'b1;
    cmp_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst       = 1'b0;
    cmp_valid = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done || busy) seen_done = 1;
    end
    check("midrst_quiet", seen_done, 0);

    // responder silent for the whole search
    x_hid = 8'h11;
    @(negedge clk);
    start     = 1'b1;
    cmp_valid = 1'b0;
    @(posedge clk);
    cyc       = 1;
    seen_done = 0;
    while (cyc < 60) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        seen_done = 1;
        break;
      end
      @(posedge clk);
      cyc++;
    end
`ifdef SAR_TIMEOUT_EN
    check("to_done_seen", seen_done, 1);
    check("to_cycles", cyc, 5);
    check("to_err", err, 1);
    check("to_steps", steps, 0);
    check("to_result", result, 0);
`else
    check("nto_no_done", seen_done, 0);
    check("nto_busy", busy, 1);
    check("nto_probe_valid", probe_valid, 1);
    check("nto_probe", probe, 8'h80);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("nto_busy_after_rst", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
